// File: rtl/pitch_snapper.sv
// pitch_snapper: request-side controller for the semitone searcher.
// Takes one detected pitch at a time, asks the searcher for the closest
// semitone, and hands the snapped target plus signed correction delta to
// the pitch-shift stage. A watchdog turns a search that never completes
// into a pass-through result flagged with timeout_out.
module pitch_snapper #(
    parameter int WIDTH   = 12,
    parameter int TIMEOUT = 256
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             pitch_valid_in,
    input  logic [WIDTH-1:0] pitch_in,
    output logic             pitch_ready_out,
    output logic             searching,
    output logic [WIDTH-1:0] search_val,
    input  logic [WIDTH-1:0] closest_value,
    input  logic             closest_value_found,
    output logic             target_valid_out,
    output logic [WIDTH-1:0] target_out,
    output logic [WIDTH:0]   delta_out,
    output logic             timeout_out,
    input  logic             target_ready_in,
    output logic             busy_out
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                   state_q;
    logic [TW-1:0]            timer_q;
    logic                     searching_q;
    logic [WIDTH-1:0]         search_val_q;
    logic                     target_valid_q;
    logic [WIDTH-1:0]         target_q;
    logic signed [WIDTH:0]    delta_q;
    logic                     timeout_q;
    logic signed [WIDTH:0]    delta_d;

    // Zero-extend both unsigned words so the difference always fits in
    // WIDTH+1 bits; no saturation is ever needed.
    function automatic logic signed [WIDTH:0] snap_delta(
        input logic [WIDTH-1:0] tgt,
        input logic [WIDTH-1:0] src
    );
        logic signed [WIDTH:0] a;
        logic signed [WIDTH:0] b;
        a = $signed({1'b0, tgt});
        b = $signed({1'b0, src});
        return a - b;
    endfunction

    // Correction delta for the searcher result currently on the bus.
    always_comb begin
        delta_d = snap_delta(closest_value, search_val_q);
    end

    // Request FSM: IDLE accepts a pitch, REQ waits for the searcher (or the
    // watchdog), DRAIN lets the found pulse fall so it cannot retrigger, OUT
    // holds the single-entry result until the consumer takes it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            searching_q    <= 1'b0;
            search_val_q   <= '0;
            target_valid_q <= 1'b0;
            target_q       <= '0;
            delta_q        <= '0;
            timeout_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Found pulses arriving here are stale and deliberately ignored.
                    if (pitch_valid_in) begin
                        search_val_q <= pitch_in;
                        timer_q      <= '0;
                        searching_q  <= 1'b1;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Found takes priority over a watchdog expiry in the same cycle.
                    if (closest_value_found) begin
                        target_q    <= closest_value;
                        delta_q     <= delta_d;
                        timeout_q   <= 1'b0;
                        searching_q <= 1'b0;
                        state_q     <= S_DRAIN;
                    end else if (timer_q == TIMER_LAST) begin
                        target_q       <= search_val_q;
                        delta_q        <= '0;
                        timeout_q      <= 1'b1;
                        searching_q    <= 1'b0;
                        target_valid_q <= 1'b1;
                        state_q        <= S_OUT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!closest_value_found) begin
                        target_valid_q <= 1'b1;
                        state_q        <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (target_valid_q && target_ready_in) begin
                        target_valid_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pitch_ready_out  = (state_q == S_IDLE);
    assign busy_out         = (state_q != S_IDLE);
    assign searching        = searching_q;
    assign search_val       = search_val_q;
    assign target_valid_out = target_valid_q;
    assign target_out       = target_q;
    assign delta_out        = delta_q;
    assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_pitch_snapper.sv
// Scoreboard bench for pitch_snapper: each issued pitch pushes its expected
// result; a negedge monitor pops and compares on every output handshake.
module tb_pitch_snapper;

    localparam int W = 12;
    localparam int T = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          pitch_valid_in = 1'b0;
    logic [W-1:0]  pitch_in = '0;
    logic          pitch_ready_out;
    logic          searching;
    logic [W-1:0]  search_val;
    logic [W-1:0]  closest_value = '0;
    logic          closest_value_found = 1'b0;
    logic          target_valid_out;
    logic [W-1:0]  target_out;
    logic [W:0]    delta_out;
    logic          timeout_out;
    logic          target_ready_in = 1'b0;
    logic          busy_out;

    pitch_snapper #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .pitch_valid_in      (pitch_valid_in),
        .pitch_in            (pitch_in),
        .pitch_ready_out     (pitch_ready_out),
        .searching           (searching),
        .search_val          (search_val),
        .closest_value       (closest_value),
        .closest_value_found (closest_value_found),
        .target_valid_out    (target_valid_out),
        .target_out          (target_out),
        .delta_out           (delta_out),
        .timeout_out         (timeout_out),
        .target_ready_in     (target_ready_in),
        .busy_out            (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] t;
        logic [W:0]   d;
        logic         to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   v_rise = -1;
    logic tv_prev = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: record valid rise time, and score every result handshake.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (target_valid_out && !tv_prev) v_rise = cyc;
            tv_prev = target_valid_out;
            if (target_valid_out && target_ready_in) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_result: got target %0h expected none", target_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("target", 32'(target_out), 32'(e.t));
                    chk("delta", 32'(delta_out), 32'(e.d));
                    chk("timeout", 32'(timeout_out), 32'(e.to));
                end
            end
        end else begin
            tv_prev = 1'b0;
        end
    end

    // One complete transaction: searcher responds after lat cycles of
    // searching, holds found for hold cycles; consumer stalls rw cycles.
    task automatic run_txn(input int pitch, input int result, input int lat,
                           input int hold, input int rw);
        exp_t e;
        int   acc;
        int   n;
        int   exp_lat;
        logic [W-1:0] t0;
        logic [W:0]   d0;
        logic         to0;
        n = 0;
        while (!pitch_ready_out && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (lat <= T - 1) begin
            e.t = W'(result);
            e.d = (W+1)'(result - pitch);
            e.to = 1'b0;
            exp_lat = lat + 1 + hold;
        end else begin
            e.t = W'(pitch);
            e.d = '0;
            e.to = 1'b1;
            exp_lat = T;
        end
        sb.push_back(e);
        pitch_valid_in = 1'b1;
        pitch_in = W'(pitch);
        v_rise = -1;
        @(posedge clk_in); #1;
        acc = cyc;
        pitch_valid_in = 1'b0;
        chk("searching_rise", 32'(searching), 32'd1);
        chk("search_val", 32'(search_val), 32'(pitch));
        repeat (lat) @(posedge clk_in);
        #1;
        closest_value = W'(result);
        closest_value_found = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_in); #1;
            if (i == 0 && lat <= T - 1) chk("searching_drop", 32'(searching), 32'd0);
        end
        closest_value_found = 1'b0;
        n = 0;
        while (!target_valid_out && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (!target_valid_out) begin
            checks++;
            errors++;
            $display("FAIL valid_wait: got no target_valid_out expected one within 100 cycles");
            return;
        end
        @(negedge clk_in); #1;
        chk("valid_latency", 32'(v_rise - acc), 32'(exp_lat));
        t0 = target_out;
        d0 = delta_out;
        to0 = timeout_out;
        pitch_valid_in = 1'b1;
        pitch_in = W'($urandom);
        repeat (rw) begin
            @(negedge clk_in);
            chk("hold_target", 32'(target_out), 32'(t0));
            chk("hold_delta", 32'(delta_out), 32'(d0));
            chk("hold_timeout", 32'(timeout_out), 32'(to0));
            chk("bp_pitch_ready", 32'(pitch_ready_out), 32'd0);
            chk("bp_searching", 32'(searching), 32'd0);
        end
        @(posedge clk_in); #1;
        target_ready_in = 1'b1;
        @(posedge clk_in); #1;
        target_ready_in = 1'b0;
        pitch_valid_in = 1'b0;
        chk("ready_after_hs", 32'(pitch_ready_out), 32'd1);
        chk("valid_cleared", 32'(target_valid_out), 32'd0);
    endtask

    // Found pulse while idle must not start anything.
    task automatic stale_found();
        closest_value = W'($urandom);
        closest_value_found = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        closest_value_found = 1'b0;
        chk("stale_busy", 32'(busy_out), 32'd0);
        chk("stale_searching", 32'(searching), 32'd0);
        chk("stale_valid", 32'(target_valid_out), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_searching", 32'(searching), 32'd0);
        chk("rst_valid", 32'(target_valid_out), 32'd0);
        chk("rst_delta", 32'(delta_out), 32'd0);
        chk("rst_target", 32'(target_out), 32'd0);
        chk("rst_timeout", 32'(timeout_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_search_val", 32'(search_val), 32'd0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("rst_pitch_ready", 32'(pitch_ready_out), 32'd1);

        // Directed cases
        run_txn(240, 247, 10, 2, 0);
        run_txn(250, 247, 3, 2, 5);
        run_txn(4095, 0, 5, 2, 1);
        run_txn(1000, 55, 30, 2, 0);
        run_txn(300, 310, T - 1, 2, 0);
        run_txn(500, 523, 4, 4, 2);
        stale_found();

        // Asynchronous reset in the middle of a request
        pitch_valid_in = 1'b1;
        pitch_in = 12'd100;
        @(posedge clk_in); #1;
        pitch_valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("midreq_searching_pre", 32'(searching), 32'd1);
        #1 rst_in = 1'b0;
        #1;
        chk("midreq_searching", 32'(searching), 32'd0);
        chk("midreq_busy", 32'(busy_out), 32'd0);
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("midreq_idle", 32'(pitch_ready_out), 32'd1);
        chk("midreq_valid", 32'(target_valid_out), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            run_txn(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 20)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) stale_found();
        end

        repeat (3) @(posedge clk_in);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pitch_snapper.md
# pitch_snapper

Request-side controller for the semitone searcher. Accepts detected pitch words from the pitch detector over a valid/ready handshake and drives the searcher's `searching`/`search_val` request. Captures `closest_value` on `closest_value_found`, computes the signed correction delta, and presents the snapped target to the pitch-shift stage over a second valid/ready handshake. A watchdog aborts a search that never completes.

## Interface
- `WIDTH`, default 12: pitch/frequency word width; must match the searcher.
- `TIMEOUT`, default 256: maximum cycles spent in REQ before abort; must be at least 4.

- `clk_in`, input, 1: clock.
- `rst_in`, input, 1: reset, asynchronous, active-low.
- `pitch_valid_in`, input, 1: pitch word available.
- `pitch_in`, input, WIDTH: detected pitch, unsigned.
- `pitch_ready_out`, output, 1: block can accept a pitch.
- `searching`, output, 1: search request to the searcher.
- `search_val`, output, WIDTH: value being searched.
- `closest_value`, input, WIDTH: searcher result.
- `closest_value_found`, input, 1: searcher result valid.
- `target_valid_out`, output, 1: result available.
- `target_out`, output, WIDTH: snapped frequency.
- `delta_out`, output, WIDTH+1: signed two's complement, `target_out` minus captured pitch.
- `timeout_out`, output, 1: current result came from an aborted search.
- `target_ready_in`, input, 1: consumer accepts the result.
- `busy_out`, output, 1: state is not IDLE.

## Operation
- States: IDLE, REQ, DRAIN, OUT. All outputs are registered except `pitch_ready_out = (state == IDLE)` and `busy_out`.
- **IDLE**
  - When `pitch_valid_in` is high, latch `pitch_in` into `search_val`, clear the timer, and go to REQ.
  - `closest_value_found` is ignored in IDLE (stale pulses).
- **REQ**
  - `searching` is high. `search_val` is held constant. The timer increments every cycle.
  - If `closest_value_found` is high:
    - latch `target_out <= closest_value`;
    - latch `delta_out <= {1'b0,closest_value} - {1'b0,search_val}`;
    - set `timeout_out <= 0`, `searching <= 0`, and go to DRAIN.
  - Otherwise, when the timer reaches `TIMEOUT-1`:
    - set `target_out <= search_val`, `delta_out <= 0`, `timeout_out <= 1`, `searching <= 0`, and go to OUT.
  - If found and timer expiry occur in the same cycle, found wins.
- **DRAIN**
  - `searching` is low.
  - Wait while `closest_value_found` is high; the searcher holds found for 2 cycles.
  - Go to OUT on the first cycle `closest_value_found` is low. This prevents re-triggering on the same found pulse.
- **OUT**
  - `target_valid_out` is high.
  - `target_out`, `delta_out`, and `timeout_out` are held stable until handshake.
  - On `target_valid_out && target_ready_in`, clear `target_valid_out` and go to IDLE.
  - No new pitch is accepted in OUT (single-entry buffer).
- Arithmetic: `delta_out` uses zero-extended WIDTH+1 operands, with no saturation. Its range is ±(2^WIDTH − 1), which always fits.
- Timer width: `$clog2(TIMEOUT)`; it does not wrap in REQ.
- Reset: `rst_in` low at any time forces IDLE immediately (asynchronous). Reset values:
  - `searching=0`, `search_val=0`, `target_valid_out=0`, `target_out=0`, `delta_out=0`, `timeout_out=0`, `busy_out=0`, timer 0;
  - `pitch_ready_out=1` once reset deasserts, with state IDLE.
  - A reset mid-REQ drops `searching` without waiting for found.
- A timeout does not rewind the searcher. The semitone table carries a top sentinel entry, so a timeout indicates a fault only.

## Timing
- Pitch accepted at edge N (IDLE→REQ). `searching` is high from cycle N+1.
- `closest_value_found` is first sampled high at edge M. At M+1, `searching` is low and the state is DRAIN.
- With found high for 2 cycles, found is low at M+2, so OUT is entered at edge M+2 and `target_valid_out` is high in cycle M+2.
- Minimum handshake: the accept edge for the next pitch is one cycle after the target handshake edge.
- Timeout: `target_valid_out` rises exactly `TIMEOUT` cycles after `searching` rises.
- Throughput: at most one search in flight.

## Test plan
- **Reset:** hold `rst_in` low and check `searching=0`, `target_valid_out=0`, `delta_out=0`. Assert `rst_in` low asynchronously mid-REQ → `searching` falls before the next clock edge and state returns to IDLE.
- **Basic, positive delta:** pitch 240, responder returns 247 after 10 cycles with found held 2 cycles → `target_out=247`, `delta_out=+7` (0x0007), `timeout_out=0`. `searching` is low one cycle after found is sampled; `target_valid_out` rises 2 cycles after found.
- **Negative delta:** pitch 250, result 247 → `delta_out=0x1FFD` (−3). Pitch 4095, result 0 → `delta_out=0x1001` (−4095).
- **Timeout:** `TIMEOUT=16`, responder never asserts found → `target_valid_out` rises 16 cycles after `searching` rises, with `target_out=search_val`, `delta_out=0`, `timeout_out=1`.
- **Backpressure:** hold `target_ready_in` low 5 cycles with `pitch_valid_in` high → outputs stable, `pitch_ready_out=0`, no second request issued. The second pitch is accepted the cycle after the handshake.
- **Races:**
  - found asserted in the same cycle as timer expiry → found result used and `timeout_out=0`;
  - stale found pulse in IDLE → ignored;
  - found held 4 cycles → DRAIN waits, and exactly one result is produced.
